// File: rtl/mcu_link_rx_if.sv
// rtl/mcu_link_rx_if.sv - MCU->ROCSTAR cable receive interface bundle
interface mcu_link_rx_if;
    logic [3:0]  in;
    logic        single_sent;
    logic        pcoinc;
    logic        ncoinc;
    logic        dcoinc;
    logic [15:0] spword;
    logic        spword_valid;
    logic        locked;
    logic        timeout;
    logic        overrun;
    logic [15:0] err_cnt;

    // Driver side: supplies the cable word and trigger pulse, observes results
    modport master (
        output in,
        output single_sent,
        input  pcoinc,
        input  ncoinc,
        input  dcoinc,
        input  spword,
        input  spword_valid,
        input  locked,
        input  timeout,
        input  overrun,
        input  err_cnt
    );

    // Receiver side
    modport slave (
        input  in,
        input  single_sent,
        output pcoinc,
        output ncoinc,
        output dcoinc,
        output spword,
        output spword_valid,
        output locked,
        output timeout,
        output overrun,
        output err_cnt
    );
endinterface

// File: rtl/mcu_link_rx.sv
// rtl/mcu_link_rx.sv - 4-bit MCU cable decoder with lock tracking and response timing
module mcu_link_rx #(
    parameter int LOCK_N       = 4,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mcu_link_rx_if.slave  link
);

    localparam logic [3:0] W_IDLE0 = 4'b0111;
    localparam logic [3:0] W_IDLE1 = 4'b1011;
    localparam logic [3:0] W_IDLE2 = 4'b1101;
    localparam logic [3:0] W_IDLE3 = 4'b1110;
    localparam logic [3:0] W_NCOIN = 4'b1001;
    localparam logic [3:0] W_PCOIN = 4'b0011;
    localparam logic [3:0] W_DCOIN = 4'b0110;
    localparam logic [3:0] W_SPECL = 4'b1100;

    localparam int LW = $clog2(LOCK_N + 1);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_CMD,
        ST_SP1,
        ST_SP2,
        ST_SP3,
        ST_SP4
    } state_t;

    // in_vld_q keeps the stale in_q seen right after reset from being decoded
    logic [3:0]    in_q;
    logic          in_vld_q;
    state_t        state_q,        state_d;
    logic [1:0]    exp_idle_q,     exp_idle_d;
    logic [LW-1:0] lock_cnt_q,     lock_cnt_d;
    logic          locked_q,       locked_d;
    logic          pending_q,      pending_d;
    logic [TW-1:0] timer_q,        timer_d;
    logic [11:0]   sp_acc_q,       sp_acc_d;
    logic [15:0]   spword_q,       spword_d;
    logic          spword_valid_q, spword_valid_d;
    logic          pcoinc_q,       pcoinc_d;
    logic          ncoinc_q,       ncoinc_d;
    logic          dcoinc_q,       dcoinc_d;
    logic          timeout_q,      timeout_d;
    logic          overrun_q,      overrun_d;
    logic [15:0]   err_cnt_q,      err_cnt_d;

    logic          idle_seen;
    logic [1:0]    idle_idx;
    logic          coin_seen;
    logic          resp_clear;
    logic          pend_after;
    logic [1:0]    err_inc;
    logic [16:0]   err_sum;

    // Next-state decode of the registered cable word and response tracker
    always_comb begin
        state_d        = state_q;
        exp_idle_d     = exp_idle_q;
        lock_cnt_d     = lock_cnt_q;
        locked_d       = locked_q;
        pending_d      = pending_q;
        timer_d        = timer_q;
        sp_acc_d       = sp_acc_q;
        spword_d       = spword_q;
        spword_valid_d = 1'b0;
        pcoinc_d       = 1'b0;
        ncoinc_d       = 1'b0;
        dcoinc_d       = 1'b0;
        timeout_d      = 1'b0;
        overrun_d      = 1'b0;
        err_cnt_d      = err_cnt_q;
        idle_seen      = 1'b0;
        idle_idx       = 2'd0;
        coin_seen      = 1'b0;
        resp_clear     = 1'b0;
        pend_after     = 1'b0;
        err_inc        = 2'd0;
        err_sum        = 17'd0;

        if (in_vld_q) begin
            case (state_q)
                ST_CMD: begin
                    case (in_q)
                        W_IDLE0: begin idle_seen = 1'b1; idle_idx = 2'd0; end
                        W_IDLE1: begin idle_seen = 1'b1; idle_idx = 2'd1; end
                        W_IDLE2: begin idle_seen = 1'b1; idle_idx = 2'd2; end
                        W_IDLE3: begin idle_seen = 1'b1; idle_idx = 2'd3; end
                        W_NCOIN: begin
                            coin_seen  = 1'b1;
                            ncoinc_d   = locked_q;
                            resp_clear = pending_q;
                        end
                        W_PCOIN: begin
                            coin_seen  = 1'b1;
                            pcoinc_d   = locked_q;
                            resp_clear = pending_q;
                        end
                        W_DCOIN: begin
                            coin_seen  = 1'b1;
                            dcoinc_d   = locked_q;
                        end
                        W_SPECL: begin
                            state_d    = ST_SP1;
                            exp_idle_d = 2'd0;
                        end
                        default: begin
                            err_inc    = err_inc + 2'd1;
                            exp_idle_d = 2'd0;
                        end
                    endcase

                    // Out-of-order IDLEs resynchronise to the word actually seen
                    if (idle_seen) begin
                        if (idle_idx == exp_idle_q) begin
                            if (lock_cnt_q != LW'(LOCK_N)) begin
                                lock_cnt_d = lock_cnt_q + LW'(1);
                            end
                        end else begin
                            err_inc = err_inc + 2'd1;
                        end
                        exp_idle_d = idle_idx + 2'd1;
                    end

                    // Coincidences are decoded even when unlocked; only the pulse is gated
                    if (coin_seen) begin
                        exp_idle_d = 2'd0;
                        if (!pending_q) begin
                            err_inc = err_inc + 2'd1;
                        end
                    end
                end
                ST_SP1: begin sp_acc_d[11:8] = in_q; state_d = ST_SP2; end
                ST_SP2: begin sp_acc_d[7:4]  = in_q; state_d = ST_SP3; end
                ST_SP3: begin sp_acc_d[3:0]  = in_q; state_d = ST_SP4; end
                ST_SP4: begin
                    spword_d       = {sp_acc_q, in_q};
                    spword_valid_d = 1'b1;
                    exp_idle_d     = 2'd0;
                    state_d        = ST_CMD;
                end
                default: state_d = ST_CMD;
            endcase
        end

        // A response in the same cycle retires the old request before a new one lands
        pend_after = pending_q & ~resp_clear;
        pending_d  = pend_after;
        if (link.single_sent) begin
            overrun_d = pend_after;
            pending_d = 1'b1;
            timer_d   = TW'(RESP_TIMEOUT);
        end else if (pend_after) begin
            if (timer_q == TW'(1)) begin
                timeout_d = 1'b1;
                pending_d = 1'b0;
                timer_d   = '0;
                err_inc   = err_inc + 2'd1;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end

        if (err_inc != 2'd0) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            err_sum    = {1'b0, err_cnt_q} + {15'd0, err_inc};
            err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end else begin
            locked_d   = (lock_cnt_d == LW'(LOCK_N));
        end
    end

    // Input capture and registered state/outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q           <= 4'd0;
            in_vld_q       <= 1'b0;
            state_q        <= ST_CMD;
            exp_idle_q     <= 2'd0;
            lock_cnt_q     <= '0;
            locked_q       <= 1'b0;
            pending_q      <= 1'b0;
            timer_q        <= '0;
            sp_acc_q       <= 12'd0;
            spword_q       <= 16'd0;
            spword_valid_q <= 1'b0;
            pcoinc_q       <= 1'b0;
            ncoinc_q       <= 1'b0;
            dcoinc_q       <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
            err_cnt_q      <= 16'd0;
        end else begin
            in_q           <= link.in;
            in_vld_q       <= 1'b1;
            state_q        <= state_d;
            exp_idle_q     <= exp_idle_d;
            lock_cnt_q     <= lock_cnt_d;
            locked_q       <= locked_d;
            pending_q      <= pending_d;
            timer_q        <= timer_d;
            sp_acc_q       <= sp_acc_d;
            spword_q       <= spword_d;
            spword_valid_q <= spword_valid_d;
            pcoinc_q       <= pcoinc_d;
            ncoinc_q       <= ncoinc_d;
            dcoinc_q       <= dcoinc_d;
            timeout_q      <= timeout_d;
            overrun_q      <= overrun_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign link.pcoinc       = pcoinc_q;
    assign link.ncoinc       = ncoinc_q;
    assign link.dcoinc       = dcoinc_q;
    assign link.spword       = spword_q;
    assign link.spword_valid = spword_valid_q;
    assign link.locked       = locked_q;
    assign link.timeout      = timeout_q;
    assign link.overrun      = overrun_q;
    assign link.err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_mcu_link_rx.sv
// tb/tb_mcu_link_rx.sv - randomized and directed bench for mcu_link_rx
module tb_mcu_link_rx;

    localparam int LOCK_N       = 4;
    localparam int RESP_TIMEOUT = 16;

    localparam logic [3:0] I0 = 4'b0111;
    localparam logic [3:0] I1 = 4'b1011;
    localparam logic [3:0] I2 = 4'b1101;
    localparam logic [3:0] I3 = 4'b1110;
    localparam logic [3:0] NC = 4'b1001;
    localparam logic [3:0] PC = 4'b0011;
    localparam logic [3:0] DC = 4'b0110;
    localparam logic [3:0] SP = 4'b1100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcu_link_rx_if link();

    mcu_link_rx #(
        .LOCK_N       (LOCK_N),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: stream parser over cycle numbers
    longint     cyc = 0;
    bit         m_wvalid;
    logic [3:0] m_word;
    int         m_exp, m_run, m_sp_left;
    logic [15:0] m_acc;
    bit         m_pend;
    longint     m_deadline;
    bit         e_p, e_n, e_d, e_spv, e_to, e_ov, e_locked;
    logic [15:0] e_sp, e_err;

    function automatic int idle_index(input logic [3:0] w);
        case (w)
            I0: return 0;
            I1: return 1;
            I2: return 2;
            I3: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_wvalid = 0; m_word = 4'd0; m_exp = 0; m_run = 0; m_sp_left = 0; m_acc = 16'd0;
        m_pend = 0; m_deadline = 0;
        e_p = 0; e_n = 0; e_d = 0; e_spv = 0; e_to = 0; e_ov = 0; e_locked = 0;
        e_sp = 16'd0; e_err = 16'd0;
    endtask

    task automatic model_step(input logic [3:0] w, input bit ss, input bit rstn);
        int  errs;
        int  k;
        bit  was_locked;
        bit  clr;
        if (!rstn) begin
            model_reset();
        end else begin
            errs = 0; clr = 0; was_locked = e_locked;
            e_p = 0; e_n = 0; e_d = 0; e_spv = 0; e_to = 0; e_ov = 0;
            if (m_wvalid) begin
                if (m_sp_left > 0) begin
                    m_acc = {m_acc[11:0], m_word};
                    m_sp_left--;
                    if (m_sp_left == 0) begin
                        e_sp = m_acc; e_spv = 1; m_exp = 0;
                    end
                end else begin
                    k = idle_index(m_word);
                    if (k >= 0) begin
                        if (k == m_exp) m_run++;
                        else errs++;
                        m_exp = (k + 1) % 4;
                    end else if (m_word == NC || m_word == PC || m_word == DC) begin
                        m_exp = 0;
                        if (was_locked) begin
                            e_n = (m_word == NC); e_p = (m_word == PC); e_d = (m_word == DC);
                        end
                        if (!m_pend) errs++;
                        else if (m_word != DC) clr = 1;
                    end else if (m_word == SP) begin
                        m_exp = 0; m_sp_left = 4; m_acc = 16'd0;
                    end else begin
                        errs++; m_exp = 0;
                    end
                end
            end
            if (clr) m_pend = 0;
            if (ss) begin
                e_ov = m_pend; m_pend = 1; m_deadline = cyc + RESP_TIMEOUT;
            end else if (m_pend && cyc == m_deadline) begin
                e_to = 1; m_pend = 0; errs++;
            end
            if (errs > 0) begin
                m_run = 0;
                e_err = (int'(e_err) + errs > 65535) ? 16'hFFFF : e_err + 16'(errs);
            end
            e_locked = (m_run >= LOCK_N);
            m_word = w; m_wvalid = 1;
        end
        cyc++;
    endtask

    task automatic compare_all();
        check_val("pcoinc",       link.pcoinc,       e_p);
        check_val("ncoinc",       link.ncoinc,       e_n);
        check_val("dcoinc",       link.dcoinc,       e_d);
        check_val("spword",       link.spword,       e_sp);
        check_val("spword_valid", link.spword_valid, e_spv);
        check_val("locked",       link.locked,       e_locked);
        check_val("timeout",      link.timeout,      e_to);
        check_val("overrun",      link.overrun,      e_ov);
        check_val("err_cnt",      link.err_cnt,      e_err);
    endtask

    // One clock: drive at negedge, model at posedge, compare at the following negedge
    task automatic cycle(input logic [3:0] w, input bit ss, input bit rstn);
        link.in = w; link.single_sent = ss; rst_n = rstn;
        @(posedge clk);
        model_step(w, ss, rstn);
        @(negedge clk);
        compare_all();
    endtask

    logic [3:0] idle_w [4];
    int pc_cnt, to_cnt, spv_cnt, k;
    int g_exp, g_sp, r, ki;
    logic [3:0] w;
    bit ss, rn;

    initial begin
        idle_w[0] = I0; idle_w[1] = I1; idle_w[2] = I2; idle_w[3] = I3;
        model_reset();
        link.in = I0; link.single_sent = 1'b0; rst_n = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(I0, 0, 0);
        cycle(I0, 0, 0);
        check_val("rst_locked", link.locked, 0);
        check_val("rst_err", link.err_cnt, 0);
        check_val("rst_spword", link.spword, 0);
        check_val("rst_pulses", {link.pcoinc, link.ncoinc, link.dcoinc, link.spword_valid,
                                 link.timeout, link.overrun}, 0);

        // Lock acquisition
        cycle(I0, 0, 1); cycle(I1, 0, 1); cycle(I2, 0, 1); cycle(I3, 0, 1);
        check_val("lock_early", link.locked, 0);
        cycle(I0, 0, 1);
        check_val("lock_set", link.locked, 1);
        check_val("lock_err", link.err_cnt, 0);

        // Prompt coincidence response
        cycle(I1, 1, 1);
        cycle(PC, 0, 1);
        check_val("pc_not_yet", link.pcoinc, 0);
        cycle(I0, 0, 1);
        check_val("pc_pulse", link.pcoinc, 1);
        pc_cnt = 0; to_cnt = 0; k = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(idle_w[k], 0, 1);
            pc_cnt += int'(link.pcoinc); to_cnt += int'(link.timeout);
            k = (k + 1) % 4;
        end
        check_val("pc_extra", pc_cnt, 0);
        check_val("pc_no_timeout", to_cnt, 0);
        check_val("pc_err", link.err_cnt, 0);
        check_val("pc_locked", link.locked, 1);

        // Special word
        cycle(SP, 0, 1); cycle(4'hA, 0, 1); cycle(4'hB, 0, 1); cycle(4'hC, 0, 1); cycle(4'hD, 0, 1);
        check_val("sp_not_yet", link.spword_valid, 0);
        cycle(I0, 0, 1);
        check_val("sp_word", link.spword, 16'hABCD);
        check_val("sp_valid", link.spword_valid, 1);
        check_val("sp_locked", link.locked, 1);
        cycle(I1, 0, 1);
        check_val("sp_valid_once", link.spword_valid, 0);

        // Out-of-order IDLE and invalid word, then relock
        cycle(I2, 0, 1); cycle(I3, 0, 1); cycle(I0, 0, 1); cycle(I1, 0, 1);
        cycle(I1, 0, 1); cycle(4'b0000, 0, 1);
        check_val("err_one", link.err_cnt, 1);
        check_val("err_unlock", link.locked, 0);
        cycle(I0, 0, 1);
        check_val("err_two", link.err_cnt, 2);
        cycle(I1, 0, 1); cycle(I2, 0, 1); cycle(I3, 0, 1);
        check_val("relock_early", link.locked, 0);
        cycle(I0, 0, 1);
        check_val("relock", link.locked, 1);
        check_val("relock_err", link.err_cnt, 2);

        // Response timeout and overrun
        cycle(I0, 0, 0);
        cycle(I0, 1, 1);
        k = 1; to_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(idle_w[k], 0, 1);
            to_cnt += int'(link.timeout);
            k = (k + 1) % 4;
        end
        check_val("to_early", to_cnt, 0);
        cycle(idle_w[k], 0, 1); k = (k + 1) % 4;
        check_val("to_pulse", link.timeout, 1);
        check_val("to_err", link.err_cnt, 1);
        cycle(idle_w[k], 1, 1); k = (k + 1) % 4;
        check_val("ov_none", link.overrun, 0);
        cycle(idle_w[k], 1, 1); k = (k + 1) % 4;
        check_val("ov_pulse", link.overrun, 1);

        // Reset in the middle of a special word
        cycle(I0, 0, 0);
        spv_cnt = 0;
        cycle(I0, 0, 1); cycle(I1, 0, 1); cycle(SP, 0, 1); cycle(4'h1, 0, 1); cycle(4'h2, 0, 1);
        spv_cnt += int'(link.spword_valid);
        cycle(4'h3, 0, 0);
        check_val("sprst_word", link.spword, 0);
        check_val("sprst_valid", link.spword_valid, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(idle_w[i % 4], 0, 1);
            spv_cnt += int'(link.spword_valid);
        end
        check_val("sprst_nopulse", spv_cnt, 0);
        check_val("sprst_cmd_lock", link.locked, 1);
        check_val("sprst_err", link.err_cnt, 0);

        // Randomized traffic against the model
        g_exp = 0; g_sp = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(99);
            if (g_sp > 0) begin
                w = 4'($urandom_range(15));
                g_sp--;
                if (g_sp == 0) g_exp = 0;
            end else if (r < 72) begin
                w = idle_w[g_exp]; g_exp = (g_exp + 1) % 4;
            end else if (r < 78) begin
                w = 4'($urandom_range(15));
                ki = idle_index(w);
                g_exp = (ki >= 0) ? (ki + 1) % 4 : 0;
            end else if (r < 84) begin
                w = SP; g_sp = 4; g_exp = 0;
            end else begin
                case ($urandom_range(2))
                    0: w = NC;
                    1: w = PC;
                    default: w = DC;
                endcase
                g_exp = 0;
            end
            ss = ($urandom_range(99) < 6);
            rn = ($urandom_range(999) != 0);
            if (!rn) begin g_exp = 0; g_sp = 0; end
            cycle(w, ss, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcu_link_rx.md
MCU_LINK_RX -- requirements
Module: mcu_link_rx

Receiver for the 4-bit MCU->ROCSTAR cable stream, located at the ROCSTAR end. It decodes IDLE, coincidence and special-word sequences, tracks link lock and checks that every sent single gets a response.

Interface
REQ-001 Parameter LOCK_N, default 4: number of consecutive correctly ordered IDLE words required to assert lock.
REQ-002 Parameter RESP_TIMEOUT, default 16: maximum number of clk cycles from single_sent to a coincidence response.
REQ-003 clk  input  1  100 MHz system clock; every flip-flop uses its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in  input  4  cable word from the MCU, one word per clk.
REQ-006 single_sent  input  1  one-cycle pulse: this board sent a single-photon trigger to the MCU.
REQ-007 pcoinc  output  1  one-cycle pulse: prompt coincidence received.
REQ-008 ncoinc  output  1  one-cycle pulse: no-coincidence received.
REQ-009 dcoinc  output  1  one-cycle pulse: delayed coincidence received.
REQ-010 spword  output  16  last complete special word received.
REQ-011 spword_valid  output  1  one-cycle pulse: spword has just been updated.
REQ-012 locked  output  1  link framing is valid.
REQ-013 timeout  output  1  one-cycle pulse: no response arrived within RESP_TIMEOUT.
REQ-014 overrun  output  1  one-cycle pulse: single_sent arrived while a response was already pending.
REQ-015 err_cnt  output  16  count of protocol errors; saturates at 16'hFFFF.

Function
REQ-016 Input handling: in shall be registered once into in_q; all decoding shall use in_q.
REQ-017 Word codes:
- IDLE0 = 0111, IDLE1 = 1011, IDLE2 = 1101, IDLE3 = 1110
- NCOIN = 1001, PCOIN = 0011, DCOIN = 0110, SPECL = 1100
- Any other value seen in command position is invalid.
REQ-018 Decoder state machine states: CMD, SP1, SP2, SP3, SP4.
REQ-019 From CMD, SPECL shall move to SP1; every other word shall leave the state in CMD.
REQ-020 SP1..SP4 shall capture in_q as raw data without decoding, in order: SP1 = bits 15:12, SP2 = 11:8, SP3 = 7:4, SP4 = 3:0. SP1->SP2->SP3->SP4->CMD.
REQ-021 On leaving SP4, spword shall update and spword_valid shall pulse in the same cycle.
REQ-022 IDLE ordering: the expected next IDLE follows IDLE0->IDLE1->IDLE2->IDLE3->IDLE0.
REQ-023 After any non-IDLE command word, or after SP4, the only valid next IDLE is IDLE0.
REQ-024 A correctly ordered IDLE shall increment the lock counter; locked shall assert when the count reaches LOCK_N.
REQ-025 Each of the following is one error, adding 1 to err_cnt (saturating), deasserting locked and clearing the lock counter:
- an out-of-order IDLE
- an invalid word in command position
- a coincidence word received while no response is pending
- a timeout
REQ-026 NCOIN, PCOIN and DCOIN shall each pulse their output only while locked. The pulse appears 2 cycles after the word is on in: one cycle for the in_q register, one for the output register.
REQ-027 Coincidence words received while unlocked produce no pulse, but still take part in IDLE-order tracking.
REQ-028 Response tracking: single_sent shall set pending and load a timer with RESP_TIMEOUT.
REQ-029 A decoded NCOIN or PCOIN shall clear pending. DCOIN shall not affect pending.
REQ-030 If the timer reaches 0 while pending is set, the block shall pulse timeout, clear pending and count one error.
REQ-031 single_sent while pending is set shall pulse overrun and reload the timer.
REQ-032 If single_sent and a clearing response occur in the same cycle, the response clears the old pending and the new single sets pending.
REQ-033 When err_cnt is 16'hFFFF, further errors shall leave it at 16'hFFFF.

Reset
REQ-034 With rst_n low at a clk edge, the block shall reset as follows:
- state = CMD, expected IDLE = IDLE0, lock counter = 0
- locked = 0, pending = 0
- pcoinc, ncoinc, dcoinc, spword_valid, timeout and overrun = 0
- spword = 0, err_cnt = 0
REQ-035 A reset received in SP1..SP4 shall discard the partial special word; spword keeps 0 and spword_valid does not pulse.

Verification
REQ-036 Drive 0111,1011,1101,1110 repeatedly from reset -> locked = 1 by the cycle after the 4th IDLE is registered; err_cnt = 0.
REQ-037 While locked, pulse single_sent, then drive PCOIN followed by 0111 -> pcoinc pulses once, 2 cycles after PCOIN; no timeout; err_cnt unchanged.
REQ-038 While locked, drive 1100,A,B,C,D then 0111 -> spword = 16'hABCD and spword_valid pulses once; locked stays 1.
REQ-039 While locked, drive IDLE1 after IDLE1, then drive the invalid word 0000 -> err_cnt increments by 2; locked = 0; relock after 4 ordered IDLEs.
REQ-040 Pulse single_sent and send no response for 16 cycles -> timeout pulses once and err_cnt = 1. A second single_sent while pending -> overrun pulses.
REQ-041 Drive 1100,1,2 then pulse rst_n low -> spword = 0, spword_valid never pulses, state returns to CMD.
